// File: rtl/i2c_follower.sv
`timescale 1ns/1ps
// i2c_follower: I2C target (7-bit address DEV_ADDR) fronting a 2^MEM_AW byte memory
// with a 16-bit register address, sequential write/read and a persistent pointer.
// Latency: SDA updates 3 clocks after the SCL pin edge (5 with the glitch filter).
// Backpressure: none; the leader owns SCL and this block never stretches the clock.
//
// Ports:
//   CLK_50MHz  in     system clock (only clock)
//   RESET      in     synchronous active-high reset
//   SCL        in     I2C clock from the leader (never driven)
//   SDA        inout  I2C data, open-drain (0 or Z only)
//   WP         in     write-protect, high suppresses memory writes
//   BUSY       out    high while this device is addressed
//   WR_STROBE  out    one-cycle pulse per byte stored into memory
//   PTR        out    current memory address pointer
//
// Build option: define I2C_FOLLOWER_GLITCH_FILTER_EN to add a 3-sample majority
// filter on synchronized SCL/SDA (rejects 1-clock pulses, +2 clocks latency).
// Register address bytes are combined as {hi,lo}; MEM_AW is assumed <= 16.

module i2c_follower #(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         MEM_AW   = 8
) (
  input  logic              CLK_50MHz,
  input  logic              RESET,
  input  logic              SCL,
  inout  wire               SDA,
  input  logic              WP,
  output logic              BUSY,
  output logic              WR_STROBE,
  output logic [MEM_AW-1:0] PTR
);

  localparam int DEPTH = 1 << MEM_AW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEV_ADDR,
    S_ADDR_HI,
    S_ADDR_LO,
    S_WR_DATA,
    S_RD_DATA,
    S_IGNORE
  } state_t;

  // --------------------------------------------------------------------------
  // Input synchronization. These flops are deliberately not reset: they keep
  // tracking the pins while RESET is high, so releasing reset in the middle of
  // a transfer cannot fabricate a START/STOP from stale history.
  // --------------------------------------------------------------------------
  logic r_scl_s1, r_scl_s2;
  logic r_sda_s1, r_sda_s2;

  always_ff @(posedge CLK_50MHz) begin
    r_scl_s1 <= SCL;
    r_scl_s2 <= r_scl_s1;
    r_sda_s1 <= SDA;
    r_sda_s2 <= r_sda_s1;
  end

  logic w_scl;
  logic w_sda;

`ifdef I2C_FOLLOWER_GLITCH_FILTER_EN
  // Majority of the current and two previous synchronized samples, registered.
  // A level change needs two agreeing samples plus the output register, so a
  // single-clock pulse never reaches the output.
  logic [1:0] r_scl_h;
  logic [1:0] r_sda_h;
  logic       r_scl_f;
  logic       r_sda_f;

  always_ff @(posedge CLK_50MHz) begin
    r_scl_h <= {r_scl_h[0], r_scl_s2};
    r_sda_h <= {r_sda_h[0], r_sda_s2};
    r_scl_f <= (r_scl_s2 & r_scl_h[0]) | (r_scl_s2 & r_scl_h[1]) | (r_scl_h[0] & r_scl_h[1]);
    r_sda_f <= (r_sda_s2 & r_sda_h[0]) | (r_sda_s2 & r_sda_h[1]) | (r_sda_h[0] & r_sda_h[1]);
  end

  assign w_scl = r_scl_f;
  assign w_sda = r_sda_f;
`else
  assign w_scl = r_scl_s2;
  assign w_sda = r_sda_s2;
`endif

  // Previous conditioned sample for edge detection.
  logic r_scl_p;
  logic r_sda_p;

  always_ff @(posedge CLK_50MHz) begin
    r_scl_p <= w_scl;
    r_sda_p <= w_sda;
  end

  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;

  assign w_scl_rise = w_scl & ~r_scl_p;
  assign w_scl_fall = ~w_scl & r_scl_p;
  // SDA moving while SCL is held high is a bus condition, never data.
  assign w_start    = w_scl & r_scl_p & r_sda_p & ~w_sda;
  assign w_stop     = w_scl & r_scl_p & ~r_sda_p & w_sda;

  // --------------------------------------------------------------------------
  // Memory. Not reset; written one cycle after the byte is accepted, in the
  // same cycle WR_STROBE is high.
  // --------------------------------------------------------------------------
  logic [7:0]        r_mem [0:DEPTH-1];
  logic [MEM_AW-1:0] r_wr_addr;
  logic [7:0]        r_wr_dat;
  logic              r_wr_strobe;
  logic [7:0]        w_mem_rdat;
  logic [MEM_AW-1:0] r_ptr;

  always_ff @(posedge CLK_50MHz) begin
    if (r_wr_strobe) begin
      r_mem[r_wr_addr] <= r_wr_dat;
    end
  end

  assign w_mem_rdat = r_mem[r_ptr];

  // --------------------------------------------------------------------------
  // Protocol FSM.
  // r_bit_cnt: 0..7 data bits in flight, 8 = byte done (ACK slot being set up on
  // the next fall), 9 = ACK clock has risen (ACK slot ends on the next fall).
  // --------------------------------------------------------------------------
  state_t            r_state;
  logic [3:0]        r_bit_cnt;
  logic [7:0]        r_shift;
  logic [7:0]        r_addr_hi;
  logic              r_rw;
  logic              r_sda_oe;
  logic              r_busy;

  logic [15:0]       w_full_addr;
  logic [MEM_AW-1:0] w_new_ptr;
  logic              w_unused_addr;

  assign w_full_addr   = {r_addr_hi, r_shift};
  assign w_new_ptr     = w_full_addr[MEM_AW-1:0];
  // Upper address bits beyond the memory size are accepted and dropped.
  assign w_unused_addr = ^w_full_addr;

  always_ff @(posedge CLK_50MHz) begin
    if (RESET) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= 4'd0;
      r_shift     <= 8'd0;
      r_addr_hi   <= 8'd0;
      r_rw        <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_dat    <= 8'd0;
      r_ptr       <= '0;
    end else begin
      r_wr_strobe <= 1'b0;

      if (w_stop) begin
        r_state   <= S_IDLE;
        r_bit_cnt <= 4'd0;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b0;
      end else if (w_start) begin
        // Also a repeated START: any partial byte is simply dropped.
        r_state   <= S_DEV_ADDR;
        r_bit_cnt <= 4'd0;
        r_shift   <= 8'd0;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_IGNORE: begin
            // Wait for the next START or STOP.
          end

          S_RD_DATA: begin
            if (w_scl_rise) begin
              if (r_bit_cnt < 4'd8) begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end else if (r_bit_cnt == 4'd8) begin
                // Leader's ACK bit. The byte has been transferred either way,
                // so the pointer advances on ACK and NACK alike.
                r_ptr <= r_ptr + MEM_AW'(1);
                if (w_sda) begin
                  r_state   <= S_IGNORE;
                  r_bit_cnt <= 4'd0;
                end else begin
                  r_bit_cnt <= 4'd9;
                end
              end
            end else if (w_scl_fall) begin
              if (r_bit_cnt == 4'd8) begin
                r_sda_oe <= 1'b0;
              end else if (r_bit_cnt == 4'd9) begin
                r_shift   <= w_mem_rdat;
                r_sda_oe  <= ~w_mem_rdat[7];
                r_bit_cnt <= 4'd0;
              end else if (r_bit_cnt != 4'd0) begin
                r_shift  <= {r_shift[6:0], 1'b0};
                r_sda_oe <= ~r_shift[6];
              end
            end
          end

          default: begin
            // Receive states: DEV_ADDR, ADDR_HI, ADDR_LO, WR_DATA.
            if (w_scl_rise) begin
              if (r_bit_cnt < 4'd8) begin
                r_shift   <= {r_shift[6:0], w_sda};
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end else if (r_bit_cnt == 4'd8) begin
                r_bit_cnt <= 4'd9;
              end
            end else if (w_scl_fall) begin
              if (r_bit_cnt == 4'd8) begin
                // Byte complete: act on it and open the ACK slot.
                case (r_state)
                  S_DEV_ADDR: begin
                    if (r_shift[7:1] == DEV_ADDR) begin
                      r_rw     <= r_shift[0];
                      r_busy   <= 1'b1;
                      r_sda_oe <= 1'b1;
                    end else begin
                      r_state   <= S_IGNORE;
                      r_bit_cnt <= 4'd0;
                    end
                  end
                  S_ADDR_HI: begin
                    r_addr_hi <= r_shift;
                    r_sda_oe  <= 1'b1;
                  end
                  S_ADDR_LO: begin
                    r_ptr    <= w_new_ptr;
                    r_sda_oe <= 1'b1;
                  end
                  S_WR_DATA: begin
                    if (!WP) begin
                      r_wr_addr   <= r_ptr;
                      r_wr_dat    <= r_shift;
                      r_wr_strobe <= 1'b1;
                    end
                    r_ptr    <= r_ptr + MEM_AW'(1);
                    r_sda_oe <= 1'b1;
                  end
                  default: begin
                  end
                endcase
              end else if (r_bit_cnt == 4'd9) begin
                // End of our ACK slot: release SDA and move on.
                r_sda_oe  <= 1'b0;
                r_bit_cnt <= 4'd0;
                r_shift   <= 8'd0;
                case (r_state)
                  S_DEV_ADDR: begin
                    if (r_rw) begin
                      // Current-address read: first bit goes out right now.
                      r_state  <= S_RD_DATA;
                      r_shift  <= w_mem_rdat;
                      r_sda_oe <= ~w_mem_rdat[7];
                    end else begin
                      r_state <= S_ADDR_HI;
                    end
                  end
                  S_ADDR_HI: r_state <= S_ADDR_LO;
                  S_ADDR_LO: r_state <= S_WR_DATA;
                  default:   r_state <= S_WR_DATA;
                endcase
              end
            end
          end
        endcase
      end
    end
  end

  // Open-drain: only ever pull low.
  assign SDA       = r_sda_oe ? 1'b0 : 1'bz;
  assign BUSY      = r_busy;
  assign WR_STROBE = r_wr_strobe;
  assign PTR       = r_ptr;

endmodule

// File: tb/tb_i2c_follower.sv
`timescale 1ns/1ps
// Directed bench for i2c_follower: bit-banged I2C leader with pull-up on SDA.
module tb_i2c_follower;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       sda_drv_low = 1'b0;
  logic       wp = 1'b0;
  wire        sda_bus;
  logic       busy;
  logic       wr_strobe;
  logic [7:0] ptr;

  int total = 0;
  int bad = 0;
  int q = 10;
  int strobe_cnt = 0;
  int sda_low_cnt = 0;

  assign sda_bus = sda_drv_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_follower #(.DEV_ADDR(7'h50), .MEM_AW(8)) dut (
    .CLK_50MHz(clk),
    .RESET(rst),
    .SCL(scl),
    .SDA(sda_bus),
    .WP(wp),
    .BUSY(busy),
    .WR_STROBE(wr_strobe),
    .PTR(ptr)
  );

  always @(posedge clk) if (wr_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;
  always @(negedge clk) if (!sda_drv_low && sda_bus === 1'b0) sda_low_cnt <= sda_low_cnt + 1;

  task automatic wait_q();
    repeat (q) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_drv_low = 1'b0; wait_q();
    scl = 1'b1;         wait_q();
    sda_drv_low = 1'b1; wait_q();
    scl = 1'b0;         wait_q();
  endtask

  task automatic bus_stop();
    sda_drv_low = 1'b1; wait_q();
    scl = 1'b1;         wait_q();
    sda_drv_low = 1'b0; wait_q();
  endtask

  task automatic write_bit(input logic b);
    sda_drv_low = ~b; wait_q();
    scl = 1'b1;       wait_q(); wait_q();
    scl = 1'b0;       wait_q();
  endtask

  task automatic read_bit(output logic b);
    sda_drv_low = 1'b0; wait_q();
    scl = 1'b1;         wait_q();
    b = sda_bus;        wait_q();
    scl = 1'b0;         wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic acked);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    acked = (b === 1'b0);
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      d = {d[6:0], b};
    end
    write_bit(~ack);
  endtask

  task automatic test_reset();
    rst = 1'b1; scl = 1'b1; sda_drv_low = 1'b0; wp = 1'b0;
    repeat (6) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (wr_strobe !== 1'b0) begin bad++; $display("FAIL reset_strobe got=%b want=0", wr_strobe); end
    total++; if (ptr !== 8'h00) begin bad++; $display("FAIL reset_ptr got=%h want=00", ptr); end
    total++; if (sda_bus !== 1'b1) begin bad++; $display("FAIL reset_sda got=%b want=1", sda_bus); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write_100k();
    logic [7:0] wb [0:4];
    logic ack;
    int s0;
    wb = '{8'hA0, 8'h00, 8'h05, 8'h3C, 8'h7E};
    q = 125;
    s0 = strobe_cnt;
    bus_start();
    for (int i = 0; i < 5; i++) begin
      write_byte(wb[i], ack);
      total++; if (ack !== 1'b1) begin bad++; $display("FAIL wr_ack[%0d] got=%b want=1", i, ack); end
      if (i == 0) begin
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL wr_busy got=%b want=1", busy); end
      end
    end
    bus_stop();
    q = 10;
    wait_q();
    total++; if (strobe_cnt - s0 != 2) begin bad++; $display("FAIL wr_strobes got=%0d want=2", strobe_cnt - s0); end
    total++; if (ptr !== 8'h07) begin bad++; $display("FAIL wr_ptr got=%h want=07", ptr); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL wr_busy_stop got=%b want=0", busy); end
  endtask

  task automatic test_random_read();
    logic [7:0] wb [0:2];
    logic [7:0] d;
    logic ack;
    wb = '{8'hA0, 8'h00, 8'h05};
    bus_start();
    for (int i = 0; i < 3; i++) begin
      write_byte(wb[i], ack);
      total++; if (ack !== 1'b1) begin bad++; $display("FAIL rr_ack[%0d] got=%b want=1", i, ack); end
    end
    bus_start();
    write_byte(8'hA1, ack);
    total++; if (ack !== 1'b1) begin bad++; $display("FAIL rr_rd_ack got=%b want=1", ack); end
    read_byte(1'b1, d);
    total++; if (d !== 8'h3C) begin bad++; $display("FAIL rr_byte0 got=%h want=3c", d); end
    read_byte(1'b0, d);
    total++; if (d !== 8'h7E) begin bad++; $display("FAIL rr_byte1 got=%h want=7e", d); end
    total++; if (ptr !== 8'h07) begin bad++; $display("FAIL rr_ptr got=%h want=07", ptr); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rr_busy_pre got=%b want=1", busy); end
    bus_stop();
    wait_q();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rr_busy_stop got=%b want=0", busy); end
  endtask

  task automatic test_mismatch();
    logic ack;
    int c0;
    c0 = sda_low_cnt;
    bus_start();
    write_byte(8'hA2, ack);
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL mm_ack got=%b want=0", ack); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mm_busy got=%b want=0", busy); end
    write_byte(8'h00, ack);
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL mm_ack2 got=%b want=0", ack); end
    write_byte(8'h05, ack);
    bus_stop();
    wait_q();
    total++; if (sda_low_cnt != c0) begin bad++; $display("FAIL mm_sda_low got=%0d want=%0d", sda_low_cnt, c0); end
    total++; if (ptr !== 8'h07) begin bad++; $display("FAIL mm_ptr got=%h want=07", ptr); end
  endtask

  task automatic test_wp_wrap();
    logic ack;
    logic [7:0] d;
    int s0;
    s0 = strobe_cnt;
    bus_start();
    write_byte(8'hA0, ack); write_byte(8'h00, ack); write_byte(8'hFF, ack); write_byte(8'h5A, ack);
    bus_stop();
    wait_q();
    total++; if (strobe_cnt - s0 != 1) begin bad++; $display("FAIL wp0_strobes got=%0d want=1", strobe_cnt - s0); end
    total++; if (ptr !== 8'h00) begin bad++; $display("FAIL wp0_wrap_ptr got=%h want=00", ptr); end
    wp = 1'b1;
    s0 = strobe_cnt;
    bus_start();
    write_byte(8'hA0, ack); write_byte(8'h00, ack); write_byte(8'hFF, ack);
    write_byte(8'h11, ack);
    total++; if (ack !== 1'b1) begin bad++; $display("FAIL wp1_ack got=%b want=1", ack); end
    bus_stop();
    wait_q();
    wp = 1'b0;
    total++; if (strobe_cnt != s0) begin bad++; $display("FAIL wp1_strobes got=%0d want=0", strobe_cnt - s0); end
    total++; if (ptr !== 8'h00) begin bad++; $display("FAIL wp1_ptr got=%h want=00", ptr); end
    bus_start();
    write_byte(8'hA0, ack); write_byte(8'h00, ack); write_byte(8'hFF, ack);
    bus_start();
    write_byte(8'hA1, ack);
    read_byte(1'b0, d);
    bus_stop();
    total++; if (d !== 8'h5A) begin bad++; $display("FAIL wp1_mem got=%h want=5a", d); end
    total++; if (ptr !== 8'h00) begin bad++; $display("FAIL rd_wrap_ptr got=%h want=00", ptr); end
  endtask

  task automatic test_abort();
    logic ack;
    logic b;
    logic [7:0] d;
    int s0;
    // Seed a known byte at 0x10 that must survive reset.
    bus_start();
    write_byte(8'hA0, ack); write_byte(8'h00, ack); write_byte(8'h10, ack); write_byte(8'h33, ack);
    bus_stop();
    // Reset during the 4th data bit of 0x96.
    bus_start();
    write_byte(8'hA0, ack); write_byte(8'h00, ack); write_byte(8'h05, ack);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b0);
    sda_drv_low = 1'b0; wait_q();
    scl = 1'b1; wait_q();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (sda_bus !== 1'b1) begin bad++; $display("FAIL rst_sda got=%b want=1", sda_bus); end
    total++; if (ptr !== 8'h00) begin bad++; $display("FAIL rst_ptr got=%h want=00", ptr); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    rst = 1'b0;
    wait_q();
    scl = 1'b0; wait_q();
    write_bit(1'b0); write_bit(1'b1); write_bit(1'b1); write_bit(1'b0);
    read_bit(b);
    total++; if (b !== 1'b1) begin bad++; $display("FAIL rst_idle_ack got=%b want=1", b); end
    bus_stop();
    // STOP in the middle of a data byte.
    s0 = strobe_cnt;
    bus_start();
    write_byte(8'hA0, ack); write_byte(8'h00, ack); write_byte(8'h10, ack);
    total++; if (ptr !== 8'h10) begin bad++; $display("FAIL stopmid_ptr0 got=%h want=10", ptr); end
    write_bit(1'b1); write_bit(1'b1); write_bit(1'b1); write_bit(1'b0);
    bus_stop();
    wait_q();
    total++; if (strobe_cnt != s0) begin bad++; $display("FAIL stopmid_strobes got=%0d want=0", strobe_cnt - s0); end
    total++; if (ptr !== 8'h10) begin bad++; $display("FAIL stopmid_ptr got=%h want=10", ptr); end
    bus_start();
    write_byte(8'hA0, ack); write_byte(8'h00, ack); write_byte(8'h10, ack);
    bus_start();
    write_byte(8'hA1, ack);
    read_byte(1'b0, d);
    bus_stop();
    total++; if (d !== 8'h33) begin bad++; $display("FAIL stopmid_mem got=%h want=33", d); end
  endtask

`ifdef I2C_FOLLOWER_GLITCH_FILTER_EN
  task automatic test_glitch();
    logic ack;
    logic b;
    logic [7:0] d;
    logic [7:0] v;
    v = 8'hC3;
    bus_start();
    write_byte(8'hA0, ack); write_byte(8'h00, ack); write_byte(8'h20, ack);
    for (int i = 7; i >= 0; i--) begin
      if (i == 5) begin
        sda_drv_low = ~v[i];
        repeat (3) @(negedge clk);
        scl = 1'b1; @(negedge clk); scl = 1'b0;
        wait_q();
        scl = 1'b1; wait_q(); wait_q();
        scl = 1'b0; wait_q();
      end else begin
        write_bit(v[i]);
      end
    end
    read_bit(b);
    total++; if (b !== 1'b0) begin bad++; $display("FAIL glitch_ack got=%b want=0", b); end
    bus_stop();
    total++; if (ptr !== 8'h21) begin bad++; $display("FAIL glitch_ptr got=%h want=21", ptr); end
    bus_start();
    write_byte(8'hA0, ack); write_byte(8'h00, ack); write_byte(8'h20, ack);
    bus_start();
    write_byte(8'hA1, ack);
    read_byte(1'b0, d);
    bus_stop();
    total++; if (d !== 8'hC3) begin bad++; $display("FAIL glitch_mem got=%h want=c3", d); end
  endtask
`endif

  initial begin
    test_reset();
    test_write_100k();
    test_random_read();
    test_mismatch();
    test_wp_wrap();
    test_abort();
`ifdef I2C_FOLLOWER_GLITCH_FILTER_EN
    test_glitch();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
